// File: rtl/single_port_ram_param_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// Holds the clear-sweep state encoding, read-during-write mode codes and the byte-lane merge.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // One byte lane of a masked write: take the new byte only where the lane is enabled.
  function automatic logic [7:0] merge_lane(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/single_port_ram_param_if.sv
// Request/response bundle for the single-port RAM.
// The client drives the master side; the RAM sits on the slave side.
interface single_port_ram_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [NUM_LANES-1:0]  byte_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output wr_en, rd_en, address, data_in, byte_en,
    input  data_out, rd_valid, busy, err
  );

  modport slave (
    input  wr_en, rd_en, address, data_in, byte_en,
    output data_out, rd_valid, busy, err
  );

endinterface

// File: rtl/single_port_ram_param_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every word once, then parks in IDLE until reset.
// busy doubles as the sweep write strobe, so the array port sees one clear write per cycle.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int IDX_W          = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  ram_state_e       state;
  logic [IDX_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/single_port_ram_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and a post-reset zero-fill sweep.
module single_port_ram_param
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 2,
  parameter int DEPTH          = 4,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  single_port_ram_param_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int STAGES    = (OUT_REG != 0) ? 2 : 1;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef logic [NUM_LANES-1:0][7:0] word_t;

  logic             busy, clr_we;
  logic [IDX_W-1:0] clr_addr;

  ram_clear_fsm #(
    .DEPTH          (DEPTH),
    .IDX_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  word_t mem [DEPTH];

  logic             addr_ok, req, accept, wr_ok, rd_ok, err_d;
  logic [IDX_W-1:0] idx;
  word_t            din_w, old_word, new_word, rd_word;

  assign addr_ok = {1'b0, bus.address} < DEPTH_W;
  assign req     = bus.wr_en | bus.rd_en;
  assign accept  = req & ~busy & addr_ok;
  assign wr_ok   = accept & bus.wr_en;
  assign rd_ok   = accept & bus.rd_en;
  assign err_d   = req & ~accept;

  // Out-of-range addresses are rejected anyway; steer them to word 0 so the array read stays legal.
  assign idx      = addr_ok ? IDX_W'(bus.address) : '0;
  assign din_w    = bus.data_in;
  assign old_word = mem[idx];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign new_word[l] = merge_lane(old_word[l], din_w[l], bus.byte_en[l]);
  end

  assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && wr_ok) ? new_word : old_word;

  // Single array write port: the sweep owns it while busy, user writes only get it afterwards.
  logic             we;
  logic [IDX_W-1:0] wa;
  word_t            wd;

  always_comb begin
    we = clr_we | wr_ok;
    wa = clr_we ? clr_addr : idx;
    wd = clr_we ? '0 : new_word;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read pipeline: data stages only load alongside their valid bit, so data_out holds between reads.
  logic [STAGES:0] vld_pipe;
  word_t           dat_pipe [1:STAGES];
  logic            err_q;

  assign vld_pipe[0] = rd_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      for (int s = 1; s <= STAGES; s++) dat_pipe[s] <= '0;
      err_q <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (rd_ok) dat_pipe[1] <= rd_word;
      for (int s = 2; s <= STAGES; s++)
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      err_q <= err_d;
    end
  end

  assign bus.data_out = dat_pipe[STAGES];
  assign bus.rd_valid = vld_pipe[STAGES];
  assign bus.busy     = busy;
  assign bus.err      = err_q;

endmodule
